spi_reg_ctrl: RTL
=================

# spi_reg_ctrl

Register-access front end for the SPI master driver. It accepts single read or write requests on a valid/ready interface and packs each one into a serial frame: read/write flag, then address, then data. It then runs the start_cmd / spi_drv_rdy handshake with the driver and returns the read data, or an error, on a valid/ready response interface. It sits directly upstream of spi_drv and drives its command-interface inputs.

## Interface
- SPI_MAXLEN, 32: must equal the driver's SPI_MAXLEN.
- ADDR_W, 7: register address width.
- DATA_W, 8: register data width. FRAME = 1+ADDR_W+DATA_W; FRAME <= SPI_MAXLEN is required, and elaboration fails otherwise.
- ACK_TIMEOUT, 16: maximum cycles start_cmd stays high waiting for spi_drv_rdy to fall. Must be >= 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- sresetn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_rw  in  1  1 = read, 0 = write.
- req_addr  in  ADDR_W  register address.
- req_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  driver did not acknowledge within ACK_TIMEOUT.
- start_cmd  out  1  to driver.
- spi_drv_rdy  in  1  from driver.
- n_clks  out  $clog2(SPI_MAXLEN)+1  to driver.
- tx_data  out  SPI_MAXLEN  to driver.
- rx_miso  in  SPI_MAXLEN  from driver.

## Operation
- All outputs are registered.
- Reset values:
  - state IDLE.
  - req_ready 0; it asserts the first cycle after reset release in which spi_drv_rdy=1.
  - start_cmd 0, rsp_valid 0, rsp_err 0.
  - rsp_rdata 0, tx_data 0, n_clks 0.
- Frame packing, on acceptance:
  - tx_data[FRAME-1] = req_rw.
  - tx_data[FRAME-2 -: ADDR_W] = req_addr.
  - tx_data[DATA_W-1:0] = req_rw ? 0 : req_wdata.
  - Bits above FRAME-1 are 0. n_clks = FRAME.
- tx_data and n_clks hold stable from acceptance until the next acceptance.
- FSM states:
  - IDLE: req_ready = (spi_drv_rdy == 1). On a handshake, capture the frame and go to START.
  - START: start_cmd = 1 and the timeout counter increments each cycle.
    - spi_drv_rdy sampled 0: go to BUSY and drop start_cmd.
    - Otherwise, when the counter reaches ACK_TIMEOUT-1: go to RESP with rsp_err=1, rsp_rdata=0, start_cmd dropped.
    - Acknowledge wins over timeout in the same cycle.
  - BUSY: wait for spi_drv_rdy sampled 1. Then register rsp_rdata = req_rw ? rx_miso[DATA_W-1:0] : 0, set rsp_err=0, and go to RESP.
  - RESP: rsp_valid=1, with rsp_rdata and rsp_err stable. On rsp_ready, clear rsp_valid and go to IDLE.
- Only one request is outstanding at a time; req_ready is 0 outside IDLE.
- The timeout counter is $clog2(ACK_TIMEOUT) bits, cleared on entry to START, and saturates; it never wraps.
- Reset mid-operation: asynchronous return to all reset values. start_cmd must fall immediately on sresetn=0.

## Timing
- Request accepted at edge N: start_cmd=1 and tx_data/n_clks valid from edge N, visible in cycle N+1.
- start_cmd stays high until the edge that samples spi_drv_rdy=0. Minimum 1 cycle, maximum ACK_TIMEOUT cycles.
- Response latency: rsp_valid rises on the edge that samples spi_drv_rdy back at 1.
- Back-to-back operation: after the rsp handshake at edge M, req_ready=1 from M (cycle M+1) if spi_drv_rdy=1. Minimum 1 idle cycle between frames.
- rsp_valid stalls indefinitely under rsp_ready=0 with no data change.

## Test plan
- Write addr 0x12, data 0xA5 (defaults): tx_data=0x000012A5, n_clks=16, start_cmd high until rdy falls; rsp_valid with rsp_rdata=0x00, rsp_err=0.
- Read addr 0x05, driver model returns rx_miso=0x0000003C: tx_data=0x00008500 and rsp_rdata=0x3C.
- Driver model holds spi_drv_rdy=1 after a request: start_cmd high exactly 16 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0; next request is accepted normally.
- rsp_ready held 0 for 20 cycles after a read: rsp_valid and rsp_rdata stable and req_ready=0 throughout; after rsp_ready=1, req_ready=1 the next cycle.
- sresetn pulsed low while in BUSY: start_cmd, rsp_valid and req_ready go 0 immediately; after release with spi_drv_rdy=1, req_ready=1 and a new write completes correctly.
- Two back-to-back requests with req_valid held high: the second is accepted only after the first response handshake, and its tx_data stays stable throughout.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: register-access front end for the SPI master driver.
// Accepts one read/write request at a time, packs it into a serial frame
// {rw, addr, data}, runs the start_cmd / spi_drv_rdy handshake with the
// driver and returns read data (or a timeout error) on the response channel.
//
// Ports:
//   clk, sresetn                 clock, async active-low reset
//   req_valid/req_ready          request handshake
//   req_rw/req_addr/req_wdata    request payload (rw: 1 = read)
//   rsp_valid/rsp_ready          response handshake
//   rsp_rdata/rsp_err            response payload
//   start_cmd/spi_drv_rdy        driver command handshake
//   n_clks/tx_data/rx_miso       driver frame length, tx frame, rx frame
module spi_reg_ctrl #(
    parameter int unsigned SPI_MAXLEN  = 32,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          sresetn,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_rw,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          rsp_err,
    output logic                          start_cmd,
    input  logic                          spi_drv_rdy,
    output logic [$clog2(SPI_MAXLEN):0]   n_clks,
    output logic [SPI_MAXLEN-1:0]         tx_data,
    input  logic [SPI_MAXLEN-1:0]         rx_miso
);

    localparam int unsigned FRAME  = 1 + ADDR_W + DATA_W;
    localparam int unsigned NCLK_W = $clog2(SPI_MAXLEN) + 1;
    localparam int unsigned CNT_W  = $clog2(ACK_TIMEOUT);

    // Parameter sanity checks at elaboration.
    generate
        if (FRAME > SPI_MAXLEN) begin : g_bad_frame
            $error("spi_reg_ctrl: 1+ADDR_W+DATA_W exceeds SPI_MAXLEN");
        end
        if (ACK_TIMEOUT < 2) begin : g_bad_timeout
            $error("spi_reg_ctrl: ACK_TIMEOUT must be >= 2");
        end
        // Only the low DATA_W bits of the driver's rx frame carry read data.
        if (SPI_MAXLEN > DATA_W) begin : g_rx_hi
            logic unused_rx_hi;
            assign unused_rx_hi = ^rx_miso[SPI_MAXLEN-1:DATA_W];
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic                    req_ready_q, req_ready_d;
    logic                    start_cmd_q, start_cmd_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;
    logic [SPI_MAXLEN-1:0]   tx_data_q, tx_data_d;
    logic [NCLK_W-1:0]       n_clks_q, n_clks_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SPI_MAXLEN-1:0]   frame_c;

    // Frame packing: {rw, addr, data}, data zeroed for reads, upper bits zero.
    always_comb begin
        frame_c                  = '0;
        frame_c[FRAME-1]         = req_rw;
        frame_c[FRAME-2 -: ADDR_W] = req_addr;
        frame_c[DATA_W-1:0]      = req_rw ? '0 : req_wdata;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            start_cmd_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            tx_data_q   <= '0;
            n_clks_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            start_cmd_q <= start_cmd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            tx_data_q   <= tx_data_d;
            n_clks_q    <= n_clks_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        req_ready_d = 1'b0;
        start_cmd_d = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        tx_data_d   = tx_data_q;
        n_clks_d    = n_clks_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                req_ready_d = spi_drv_rdy;
                if (req_valid && req_ready_q) begin
                    tx_data_d   = frame_c;
                    n_clks_d    = NCLK_W'(FRAME);
                    cnt_d       = '0;
                    start_cmd_d = 1'b1;
                    req_ready_d = 1'b0;
                    state_d     = START;
                end
            end
            START: begin
                // Driver acknowledge takes priority over the timeout.
                if (!spi_drv_rdy) begin
                    state_d = BUSY;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                end else begin
                    start_cmd_d = 1'b1;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            BUSY: begin
                if (spi_drv_rdy) begin
                    // The rw flag is still held in the top frame bit.
                    rsp_rdata_d = tx_data_q[FRAME-1] ? rx_miso[DATA_W-1:0] : '0;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = spi_drv_rdy;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready = req_ready_q;
    assign start_cmd = start_cmd_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign tx_data   = tx_data_q;
    assign n_clks    = n_clks_q;

endmodule
